uart_autobaud: RTL and testbench
================================

Name: uart_autobaud

Overview:
- Baud-rate detector for the UART path, working in the opposite direction to the baud divider.
- The divider turns a divisor (integer plus half flag) into a bit clock. This block measures an incoming sync character 0x55 on rxd and produces that divisor pair.
- Its outputs feed the divider's divisor/half inputs at run time, in place of fixed parameters.

Parameters:
- F_DIV_WIDTH, 16, width of div_out; the measurement counter is F_DIV_WIDTH+3 bits.
- MIN_SEG, 4, minimum legal segment length in clocks; shorter segments are treated as glitches and flagged as errors.
- IDLE_CLKS, 64, clocks rxd must stay high before a start edge is accepted.

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rxd  in  1  asynchronous serial line, idle high
- rearm  in  1  single-cycle request to discard the lock and measure again
- div_out  out  F_DIV_WIDTH  measured bit period in clocks, integer part
- half_out  out  1  set when the fractional part of the bit period is >= 0.5
- valid  out  1  one-cycle pulse when a new div_out/half_out is loaded
- locked  out  1  level; high while div_out/half_out hold a validated result
- err  out  1  one-cycle pulse on a measurement failure

Behaviour:
- Reset and clock:
  - Single clock domain. Reset is synchronous, active-high, on clock.
  - Reset values: div_out=0, half_out=0, valid=0, locked=0, err=0, state=IDLE, all counters 0.
- Input conditioning:
  - rxd passes through a 2-FF synchronizer into rx_s.
  - fall = rx_s_d & ~rx_s. Edge detection adds 3 cycles of latency from a pin edge.
- Frame geometry: 0x55 sent LSB-first with start and stop gives line levels 0101010101. Falling edges are at bit boundaries 0, 2, 4, 6, 8, so edge 0 to edge 4 spans exactly 8 bit periods.
- States:
  - IDLE:
    - idle_cnt counts while rx_s=1 and clears when rx_s=0.
    - At idle_cnt==IDLE_CLKS-1, go to ARMED. idle_cnt saturates there.
  - ARMED: on fall, clear tot_cnt, seg_cnt, seg_idx, then go to MEASURE.
  - MEASURE:
    - tot_cnt and seg_cnt increment every cycle.
    - On any edge of rx_s:
      - If seg_idx==0, store ref_seg=seg_cnt+1.
      - Otherwise check seg_cnt+1 against the window ref_seg-(ref_seg>>2) .. ref_seg+(ref_seg>>2), inclusive.
      - Then clear seg_cnt and increment seg_idx.
    - The 8th edge (seg_idx==7) is the 4th fall after the start edge. On it, tot_final=tot_cnt+1 and the state goes to DONE.
  - DONE, lasting one cycle:
    - div_out <= tot_final[F_DIV_WIDTH+2:3].
    - half_out <= tot_final[2].
    - valid=1, locked=1.
    - Then go to LOCKED.
  - LOCKED:
    - Outputs hold and rxd is ignored.
    - rearm clears locked and goes to IDLE. div_out/half_out keep their old values until the next DONE.
  - ERR, lasting one cycle: err=1, then go to HALT (see the Optional Feature section).
- Error conditions (state goes to ERR; locked is cleared):
  - A segment falls outside the window.
  - seg_cnt+1 < MIN_SEG.
  - tot_cnt reaches all-ones (saturation).
  - div_out would be 0.
- Simultaneous events:
  - rst has priority over everything.
  - rearm in any state other than LOCKED/HALT is ignored.
  - rearm arriving in the same cycle as DONE is ignored; lock still completes.
- Reset mid-measurement: partial results are discarded and the stored div_out is zeroed.

Optional Feature:
- Macro: AUTOBAUD_RETRY_EN.
- Defined: HALT is never entered. ERR returns directly to IDLE, so measurement retries automatically on the next idle period.
- Undefined: ERR goes to HALT. HALT holds err-state outputs (locked=0) until rearm, which moves the state to IDLE.

Decomposition:
- Shared package uart_pkg:
  - State enum ab_state_t (IDLE, ARMED, MEASURE, DONE, LOCKED, ERR, HALT).
  - Constant SYNC_EDGES=8.
  - Constant SYNC_BITS_LOG2=3.
- One sub-module: uart_rx_sync. It holds the 2-FF synchronizer and the fall/rise detector and is reused by the UART receiver.

Test Plan:
- Exact integer period: with IDLE_CLKS high first, send 0x55 at 100 clocks/bit -> valid pulse, div_out=100, half_out=0, locked=1.
- Half period: bits alternate 100 and 101 clocks (total 804) -> div_out=100, half_out=1, valid once.
- Glitch: a 2-clock low pulse inside idle-qualified ARMED -> err pulse, locked=0.
  - With AUTOBAUD_RETRY_EN, a following clean 0x55 at 50 clocks/bit locks with div_out=50.
  - Without the macro, nothing locks until rearm.
- Bad character: send 0x0F at 100 clocks/bit (segment 400 vs ref 100) -> err pulse and no valid. Repeat with a line stuck low from the start edge -> err on counter saturation.
- Rearm and reset: lock at 100, pulse rearm, send 0x55 at 200 -> div_out stays 100 until the new valid, then 200. Assert rst mid-MEASURE -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   ab_state_t      : state encoding of the baud-rate detector
//   SYNC_EDGES      : edges measured after the start edge of the 0x55 sync char
//   SYNC_BITS_LOG2  : log2 of the bit periods spanned by those edges (8 bits)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        MEASURE = 3'd2,
        DONE    = 3'd3,
        LOCKED  = 3'd4,
        ERR     = 3'd5,
        HALT    = 3'd6
    } ab_state_t;

    localparam int SYNC_EDGES     = 8;
    localparam int SYNC_BITS_LOG2 = 3;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line plus edge detector.
// Ports:
//   clock_i  : system clock
//   rst_i    : synchronous reset, active-high (line flops reset to idle-high)
//   rxd_i    : asynchronous serial input, idle high
//   rx_s_o   : synchronized line level
//   fall_o   : one-cycle pulse on a 1->0 transition of rx_s_o
//   rise_o   : one-cycle pulse on a 0->1 transition of rx_s_o
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clock_i,
    input  logic rst_i,
    input  logic rxd_i,
    output logic rx_s_o,
    output logic fall_o,
    output logic rise_o
);

    logic rx_meta_q;
    logic rx_s_q;
    logic rx_s_dly_q;

    // Synchronizer chain plus one delayed copy for edge detection.
    // Reset to the idle level so leaving reset never looks like a start edge.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_s_dly_q <= 1'b1;
        end else begin
            rx_meta_q  <= rxd_i;
            rx_s_q     <= rx_meta_q;
            rx_s_dly_q <= rx_s_q;
        end
    end

    assign rx_s_o = rx_s_q;
    assign fall_o = rx_s_dly_q & ~rx_s_q;
    assign rise_o = ~rx_s_dly_q & rx_s_q;

endmodule

// File: rtl/uart_autobaud.sv
// -----------------------------------------------------------------------------
// uart_autobaud
// Measures a 0x55 sync character on rxd and produces the divisor pair
// (integer bit period plus half flag) for the UART baud divider.
// Ports:
//   clock_i     : system clock
//   rst_i       : synchronous reset, active-high
//   rxd_i       : asynchronous serial line, idle high
//   rearm_i     : single-cycle request to drop the lock and measure again
//   div_out_o   : measured bit period in clocks, integer part
//   half_out_o  : fractional part of the bit period is >= 0.5
//   valid_o     : one-cycle pulse when div_out_o/half_out_o are loaded
//   locked_o    : high while div_out_o/half_out_o hold a validated result
//   err_o       : one-cycle pulse on a measurement failure
// Build option:
//   AUTOBAUD_RETRY_EN : when defined, an error returns straight to IDLE and the
//                       next idle period retries; otherwise the block halts
//                       until rearm_i.
// -----------------------------------------------------------------------------
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int F_DIV_WIDTH = 16,
    parameter int MIN_SEG     = 4,
    parameter int IDLE_CLKS   = 64
) (
    input  logic                   clock_i,
    input  logic                   rst_i,
    input  logic                   rxd_i,
    input  logic                   rearm_i,
    output logic [F_DIV_WIDTH-1:0] div_out_o,
    output logic                   half_out_o,
    output logic                   valid_o,
    output logic                   locked_o,
    output logic                   err_o
);

    localparam int CW = F_DIV_WIDTH + SYNC_BITS_LOG2;
    localparam int IW = (IDLE_CLKS > 1) ? $clog2(IDLE_CLKS) : 1;

    logic rx_s, fall_s, rise_s, edge_s;

    ab_state_t state_q, state_d;
    logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
    logic [CW-1:0]          tot_cnt_q, tot_cnt_d;
    logic [CW-1:0]          seg_cnt_q, seg_cnt_d;
    logic [CW-1:0]          ref_seg_q, ref_seg_d;
    logic [CW-1:0]          tot_final_q, tot_final_d;
    logic [2:0]             seg_idx_q, seg_idx_d;
    logic [F_DIV_WIDTH-1:0] div_q, div_d;
    logic                   half_q, half_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;

    logic [CW-1:0] seg_len_s, tot_len_s, ref_quarter_s;
    logic [CW:0]   win_lo_s, win_hi_s;
    logic          seg_short_s, seg_out_s, last_edge_s, div_zero_s, tot_sat_s, idle_done_s;

    uart_rx_sync u_sync (
        .clock_i (clock_i),
        .rst_i   (rst_i),
        .rxd_i   (rxd_i),
        .rx_s_o  (rx_s),
        .fall_o  (fall_s),
        .rise_o  (rise_s)
    );

    assign edge_s = fall_s | rise_s;

    // Segment length includes the edge cycle itself, hence the +1.
    assign seg_len_s     = seg_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    assign tot_len_s     = tot_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    assign ref_quarter_s = {2'b00, ref_seg_q[CW-1:2]};
    // Window bounds carry one extra bit so ref + ref/4 cannot wrap.
    assign win_lo_s      = {1'b0, ref_seg_q - ref_quarter_s};
    assign win_hi_s      = {1'b0, ref_seg_q} + {1'b0, ref_quarter_s};
    assign seg_short_s   = (seg_len_s < CW'(MIN_SEG));
    assign seg_out_s     = (seg_idx_q != 3'd0) &&
                           (({1'b0, seg_len_s} < win_lo_s) || ({1'b0, seg_len_s} > win_hi_s));
    assign last_edge_s   = (seg_idx_q == 3'(SYNC_EDGES - 1));
    assign div_zero_s    = (tot_len_s[CW-1:SYNC_BITS_LOG2] == {F_DIV_WIDTH{1'b0}});
    assign tot_sat_s     = &tot_cnt_q;
    assign idle_done_s   = rx_s && (idle_cnt_q == IW'(IDLE_CLKS - 1));

    // State register.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (idle_done_s) state_d = ARMED; else state_d = IDLE;
            ARMED:   if (fall_s) state_d = MEASURE; else state_d = ARMED;
            MEASURE: begin
                if (tot_sat_s) begin
                    state_d = ERR;
                end else if (edge_s) begin
                    if (seg_short_s || seg_out_s) begin
                        state_d = ERR;
                    end else if (last_edge_s) begin
                        state_d = div_zero_s ? ERR : DONE;
                    end else begin
                        state_d = MEASURE;
                    end
                end else begin
                    state_d = MEASURE;
                end
            end
            DONE:    state_d = LOCKED;
            LOCKED:  if (rearm_i) state_d = IDLE; else state_d = LOCKED;
`ifdef AUTOBAUD_RETRY_EN
            ERR:     state_d = IDLE;
`else
            ERR:     state_d = HALT;
`endif
            HALT:    if (rearm_i) state_d = IDLE; else state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Counter and output next values for the current state.
    always_comb begin
        idle_cnt_d  = {IW{1'b0}};
        tot_cnt_d   = tot_cnt_q;
        seg_cnt_d   = seg_cnt_q;
        ref_seg_d   = ref_seg_q;
        tot_final_d = tot_final_q;
        seg_idx_d   = seg_idx_q;
        div_d       = div_q;
        half_d      = half_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    idle_cnt_d = {IW{1'b0}};
                end else if (idle_done_s) begin
                    idle_cnt_d = idle_cnt_q;
                end else begin
                    idle_cnt_d = idle_cnt_q + {{(IW-1){1'b0}}, 1'b1};
                end
            end
            ARMED: begin
                if (fall_s) begin
                    tot_cnt_d = {CW{1'b0}};
                    seg_cnt_d = {CW{1'b0}};
                    seg_idx_d = 3'd0;
                end else begin
                    seg_idx_d = seg_idx_q;
                end
            end
            MEASURE: begin
                tot_cnt_d = tot_len_s;
                if (edge_s) begin
                    if (seg_idx_q == 3'd0) begin
                        ref_seg_d = seg_len_s;
                    end else begin
                        ref_seg_d = ref_seg_q;
                    end
                    if (last_edge_s) begin
                        tot_final_d = tot_len_s;
                    end else begin
                        tot_final_d = tot_final_q;
                    end
                    seg_cnt_d = {CW{1'b0}};
                    seg_idx_d = seg_idx_q + 3'd1;
                end else begin
                    seg_cnt_d = seg_len_s;
                end
            end
            DONE: begin
                div_d    = tot_final_q[CW-1:SYNC_BITS_LOG2];
                half_d   = tot_final_q[SYNC_BITS_LOG2-1];
                valid_d  = 1'b1;
                locked_d = 1'b1;
            end
            LOCKED:  locked_d = ~rearm_i;
            ERR: begin
                err_d    = 1'b1;
                locked_d = 1'b0;
            end
            HALT:    locked_d = 1'b0;
            default: locked_d = 1'b0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            idle_cnt_q  <= {IW{1'b0}};
            tot_cnt_q   <= {CW{1'b0}};
            seg_cnt_q   <= {CW{1'b0}};
            ref_seg_q   <= {CW{1'b0}};
            tot_final_q <= {CW{1'b0}};
            seg_idx_q   <= 3'd0;
            div_q       <= {F_DIV_WIDTH{1'b0}};
            half_q      <= 1'b0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            idle_cnt_q  <= idle_cnt_d;
            tot_cnt_q   <= tot_cnt_d;
            seg_cnt_q   <= seg_cnt_d;
            ref_seg_q   <= ref_seg_d;
            tot_final_q <= tot_final_d;
            seg_idx_q   <= seg_idx_d;
            div_q       <= div_d;
            half_q      <= half_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign div_out_o  = div_q;
    assign half_out_o = half_q;
    assign valid_o    = valid_q;
    assign locked_o   = locked_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// -----------------------------------------------------------------------------
// tb_uart_autobaud
// Directed bench for uart_autobaud with a narrow divisor (F_DIV_WIDTH=8) so the
// measurement counter saturates after 2047 clocks.
// -----------------------------------------------------------------------------
module tb_uart_autobaud;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       rxd   = 1'b1;
    logic       rearm = 1'b0;
    logic [7:0] div_out;
    logic       half_out, valid, locked, err;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int exp_valid = 0;
    int exp_err   = 0;

    always #5 clock = ~clock;

    uart_autobaud #(
        .F_DIV_WIDTH (8),
        .MIN_SEG     (4),
        .IDLE_CLKS   (64)
    ) dut (
        .clock_i    (clock),
        .rst_i      (rst),
        .rxd_i      (rxd),
        .rearm_i    (rearm),
        .div_out_o  (div_out),
        .half_out_o (half_out),
        .valid_o    (valid),
        .locked_o   (locked),
        .err_o      (err)
    );

    // Count pulse-cycles of valid and err, sampled away from the active edge.
    always @(negedge clock) begin
        if (!rst && valid) valid_cnt <= valid_cnt + 1;
        if (!rst && err)   err_cnt   <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_rearm();
        rearm = 1'b1;
        @(negedge clock);
        rearm = 1'b0;
        @(negedge clock);
    endtask

    // Drive frame bits b0..b1 of {stop, ch, start}; odd bits get 'extra' clocks.
    task automatic send_frame(input logic [7:0] ch, input int per, input int extra,
                              input int b0, input int b1);
        logic [9:0] fr;
        fr = {1'b1, ch, 1'b0};
        for (int i = b0; i <= b1; i++) begin
            rxd = fr[i];
            repeat (per + (((i % 2) == 1) ? extra : 0)) @(negedge clock);
        end
    endtask

    initial begin
        // Reset state
        repeat (4) @(negedge clock);
        check("rst_div", 32'(div_out), 32'd0);
        check("rst_half", 32'(half_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Exact period of 100 clocks/bit
        idle(80);
        send_frame(8'h55, 100, 0, 0, 9);
        exp_valid = 1;
        check("p100_valid", 32'(valid_cnt), 32'(exp_valid));
        check("p100_div", 32'(div_out), 32'd100);
        check("p100_half", 32'(half_out), 32'd0);
        check("p100_locked", 32'(locked), 32'd1);
        check("p100_err", 32'(err_cnt), 32'(exp_err));

        // Half period: 100/101 alternating, 804 clocks over 8 bits
        pulse_rearm();
        check("rearm_unlock", 32'(locked), 32'd0);
        idle(80);
        send_frame(8'h55, 100, 1, 0, 9);
        exp_valid = 2;
        check("half_valid", 32'(valid_cnt), 32'(exp_valid));
        check("half_div", 32'(div_out), 32'd100);
        check("half_half", 32'(half_out), 32'd1);
        check("half_locked", 32'(locked), 32'd1);

        // Bad character 0x0F: 400-clock segment against a 100-clock reference
        pulse_rearm();
        idle(80);
        send_frame(8'h0F, 100, 0, 0, 9);
        exp_err = 1;
        check("bad_err", 32'(err_cnt), 32'(exp_err));
        check("bad_valid", 32'(valid_cnt), 32'(exp_valid));
        check("bad_locked", 32'(locked), 32'd0);
        pulse_rearm();

        // Line stuck low after the start edge: counter saturation
        idle(80);
        rxd = 1'b0;
        repeat (2100) @(negedge clock);
        exp_err = 2;
        check("stuck_err", 32'(err_cnt), 32'(exp_err));
        check("stuck_locked", 32'(locked), 32'd0);
        idle(4);
        pulse_rearm();

        // Glitch: 2-clock low pulse while armed
        idle(80);
        rxd = 1'b0;
        repeat (2) @(negedge clock);
        idle(20);
        exp_err = 3;
        check("glitch_err", 32'(err_cnt), 32'(exp_err));
        check("glitch_locked", 32'(locked), 32'd0);
`ifndef AUTOBAUD_RETRY_EN
        // Halted: a clean frame must not lock until rearm
        idle(80);
        send_frame(8'h55, 50, 0, 0, 9);
        check("halt_valid", 32'(valid_cnt), 32'(exp_valid));
        check("halt_locked", 32'(locked), 32'd0);
        pulse_rearm();
`endif
        idle(80);
        send_frame(8'h55, 50, 0, 0, 9);
        exp_valid = 3;
        check("p50_valid", 32'(valid_cnt), 32'(exp_valid));
        check("p50_div", 32'(div_out), 32'd50);
        check("p50_locked", 32'(locked), 32'd1);

        // Relock at 100, then rearm and measure 200; old value holds until valid
        pulse_rearm();
        idle(80);
        send_frame(8'h55, 100, 0, 0, 9);
        exp_valid = 4;
        check("re100_div", 32'(div_out), 32'd100);
        pulse_rearm();
        check("re_locked", 32'(locked), 32'd0);
        check("re_hold_div", 32'(div_out), 32'd100);
        idle(80);
        send_frame(8'h55, 200, 0, 0, 3);
        check("mid_div", 32'(div_out), 32'd100);
        check("mid_valid", 32'(valid_cnt), 32'(exp_valid));
        send_frame(8'h55, 200, 0, 4, 9);
        exp_valid = 5;
        check("p200_valid", 32'(valid_cnt), 32'(exp_valid));
        check("p200_div", 32'(div_out), 32'd200);
        check("p200_half", 32'(half_out), 32'd0);
        check("p200_locked", 32'(locked), 32'd1);

        // Reset in the middle of a measurement
        pulse_rearm();
        idle(80);
        send_frame(8'h55, 100, 0, 0, 3);
        rst = 1'b1;
        @(negedge clock);
        check("mrst_div", 32'(div_out), 32'd0);
        check("mrst_half", 32'(half_out), 32'd0);
        check("mrst_valid", 32'(valid), 32'd0);
        check("mrst_locked", 32'(locked), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        rst = 1'b0;
        rxd = 1'b1;
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
